// File: rtl/atm_session_ctrl.sv
// ATM session front-end: card/PIN check with lockout, one command per request to the core.
// Optional idle timeout of WAIT_PIN/MENU enabled by defining SESSION_TIMEOUT_EN.
module atm_session_ctrl #(
  parameter int MAX_TRIES   = 3,
  parameter int ACCT_W      = 4,
  parameter int AMT_W       = 10,
  parameter int PIN_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              card_in,
  input  logic [ACCT_W-1:0] card_acct,
  input  logic              pin_valid,
  input  logic [PIN_W-1:0]  pin_value,
  output logic [ACCT_W-1:0] pin_lookup_acct,
  input  logic [PIN_W-1:0]  pin_lookup_val,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_select,
  input  logic [ACCT_W-1:0] cmd_dest_acct,
  input  logic [AMT_W-1:0]  cmd_amount,
  output logic              core_req_valid,
  input  logic              core_req_ready,
  output logic [1:0]        core_select,
  output logic [ACCT_W-1:0] core_origin,
  output logic [ACCT_W-1:0] core_purpose,
  output logic [AMT_W-1:0]  core_amount,
  input  logic              core_resp_valid,
  input  logic [1:0]        core_result,
  input  logic [AMT_W-1:0]  core_inventory,
  output logic              disp_valid,
  output logic [1:0]        disp_result,
  output logic [AMT_W-1:0]  disp_inventory,
  output logic              card_eject,
  output logic              acct_locked,
  output logic              session_active
);

  localparam int NACCT = 1 << ACCT_W;
  localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE, WAIT_PIN, CHECK_PIN, MENU, ISSUE, WAIT_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ACCT_W-1:0] acct_q, acct_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic [2:0]        tries_q, tries_d;
  logic [NACCT-1:0]  lock_q, lock_d;
  logic [1:0]        sel_q, sel_d;
  logic [ACCT_W-1:0] dest_q, dest_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [1:0]        res_q, res_d;
  logic [AMT_W-1:0]  inv_q, inv_d;
  logic              disp_q, disp_d;
  logic              eject_q, eject_d;
  logic              locked_q, locked_d;
  logic              active_q, active_d;

`ifdef SESSION_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             evt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acct_q   <= '0;
      pin_q    <= '0;
      tries_q  <= '0;
      lock_q   <= '0;
      sel_q    <= '0;
      dest_q   <= '0;
      amt_q    <= '0;
      res_q    <= '0;
      inv_q    <= '0;
      disp_q   <= 1'b0;
      eject_q  <= 1'b0;
      locked_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acct_q   <= acct_d;
      pin_q    <= pin_d;
      tries_q  <= tries_d;
      lock_q   <= lock_d;
      sel_q    <= sel_d;
      dest_q   <= dest_d;
      amt_q    <= amt_d;
      res_q    <= res_d;
      inv_q    <= inv_d;
      disp_q   <= disp_d;
      eject_q  <= eject_d;
      locked_q <= locked_d;
      active_q <= active_d;
    end
  end

`ifdef SESSION_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    acct_d   = acct_q;
    pin_d    = pin_q;
    tries_d  = tries_q;
    lock_d   = lock_q;
    sel_d    = sel_q;
    dest_d   = dest_q;
    amt_d    = amt_q;
    res_d    = res_q;
    inv_d    = inv_q;
    disp_d   = 1'b0;
    eject_d  = 1'b0;
    locked_d = 1'b0;
    active_d = active_q;
    unique case (state_q)
      IDLE: begin
        if (card_in) begin
          acct_d = card_acct;
          if (lock_q[card_acct]) begin
            locked_d = 1'b1;
            eject_d  = 1'b1;
          end else begin
            state_d = WAIT_PIN;
            tries_d = '0;
          end
        end
      end
      WAIT_PIN: begin
        if (pin_valid) begin
          pin_d   = pin_value;
          state_d = CHECK_PIN;
        end
      end
      CHECK_PIN: begin
        if (pin_q == pin_lookup_val) begin
          state_d  = MENU;
          active_d = 1'b1;
          tries_d  = '0;
        end else if (tries_q + 3'd1 >= MAX_T) begin
          tries_d        = tries_q + 3'd1;
          lock_d[acct_q] = 1'b1;
          locked_d       = 1'b1;
          eject_d        = 1'b1;
          state_d        = IDLE;
        end else begin
          tries_d = tries_q + 3'd1;
          state_d = WAIT_PIN;
        end
      end
      MENU: begin
        if (cmd_valid) begin
          sel_d  = cmd_select;
          dest_d = cmd_dest_acct;
          amt_d  = cmd_amount;
          if (cmd_select == 2'b11) begin
            eject_d  = 1'b1;
            active_d = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (core_req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (core_resp_valid) begin
          res_d   = core_result;
          inv_d   = core_inventory;
          disp_d  = 1'b1;
          state_d = MENU;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SESSION_TIMEOUT_EN
    // Any accepted input restarts the idle count; ISSUE/WAIT_RESP hold it.
    tmo_d = tmo_q;
    evt = (state_q == IDLE && card_in) ||
          (state_q == WAIT_PIN && pin_valid) ||
          (state_q == MENU && cmd_valid);
    if (evt) begin
      tmo_d = '0;
    end else if (state_q == WAIT_PIN || state_q == MENU) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d    = '0;
        state_d  = IDLE;
        eject_d  = 1'b1;
        active_d = 1'b0;
        tries_d  = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  assign pin_lookup_acct = acct_q;
  assign core_req_valid  = (state_q == ISSUE);
  assign core_select     = sel_q;
  assign core_origin     = acct_q;
  assign core_purpose    = dest_q;
  assign core_amount     = amt_q;
  assign disp_valid      = disp_q;
  assign disp_result     = res_q;
  assign disp_inventory  = inv_q;
  assign card_eject      = eject_q;
  assign acct_locked     = locked_q;
  assign session_active  = active_q;

endmodule
